// File: rtl/data_memory_ctrl_if.sv
// Request/response bus of the SimpleRISC data memory.
// The master drives requests; the slave (the memory) drives ready and the registered response.
interface data_memory_ctrl_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              is_ld;
  logic              is_st;
  logic [1:0]        size;
  logic              sign_ext;
  logic [ADDR_W-1:0] address;
  logic [31:0]       data_in;
  logic              resp_valid;
  logic [31:0]       data_out;
  logic              err;

  modport master (
    output req_valid, is_ld, is_st, size, sign_ext, address, data_in,
    input  req_ready, resp_valid, data_out, err
  );

  modport slave (
    input  req_valid, is_ld, is_st, size, sign_ext, address, data_in,
    output req_ready, resp_valid, data_out, err
  );
endinterface

// File: rtl/data_memory_ctrl.sv
// Byte-addressed data memory with byte/half/word access and a one-cycle registered response.
// After reset, a sweep writes INIT_VAL to every word before requests are accepted.
module data_memory_ctrl #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DEPTH    = 256,
  parameter logic [31:0] INIT_VAL = 32'h0
) (
  input logic               clk,
  input logic               rst,
  data_memory_ctrl_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  typedef enum logic {ST_INIT, ST_READY} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic              ready_q, ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       data_out_q, data_out_d;
  logic              err_q, err_d;

  logic [31:0]       mem_q [DEPTH];
  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [31:0]       mem_wdata;

  logic              accept;
  logic              req_err;
  logic              out_of_range;
  logic [ADDR_W-1:0] addr_hi;
  logic [IDX_W-1:0]  idx;
  logic [1:0]        lane;
  logic [31:0]       rd_word;
  logic [31:0]       st_word;
  logic [31:0]       ld_data;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;

  assign accept       = bus.req_valid & ready_q;
  assign idx          = bus.address[IDX_W+1:2];
  assign lane         = bus.address[1:0];
  assign addr_hi      = bus.address >> (IDX_W + 2);
  assign out_of_range = |addr_hi;
  // The word is read before this edge's write lands, so a load sees only earlier stores.
  assign rd_word      = mem_q[idx];

  // Legality of the presented request.
  always_comb begin
    req_err = 1'b0;
    if (bus.is_ld == bus.is_st)                      req_err = 1'b1;
    if (bus.size == 2'b11)                           req_err = 1'b1;
    if (out_of_range)                                req_err = 1'b1;
    if (bus.size == 2'b01 && bus.address[0])         req_err = 1'b1;
    if (bus.size == 2'b10 && bus.address[1:0] != 2'b00) req_err = 1'b1;
  end

  // Lane merge for stores and lane extract/extend for loads.
  always_comb begin
    st_word = rd_word;
    ld_data = '0;
    unique case (lane)
      2'd0:    ld_byte = rd_word[7:0];
      2'd1:    ld_byte = rd_word[15:8];
      2'd2:    ld_byte = rd_word[23:16];
      default: ld_byte = rd_word[31:24];
    endcase
    ld_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
    unique case (bus.size)
      2'b00: begin
        unique case (lane)
          2'd0:    st_word[7:0]   = bus.data_in[7:0];
          2'd1:    st_word[15:8]  = bus.data_in[7:0];
          2'd2:    st_word[23:16] = bus.data_in[7:0];
          default: st_word[31:24] = bus.data_in[7:0];
        endcase
        ld_data = bus.sign_ext ? {{24{ld_byte[7]}}, ld_byte} : {24'h0, ld_byte};
      end
      2'b01: begin
        if (lane[1]) st_word[31:16] = bus.data_in[15:0];
        else         st_word[15:0]  = bus.data_in[15:0];
        ld_data = bus.sign_ext ? {{16{ld_half[15]}}, ld_half} : {16'h0, ld_half};
      end
      default: begin
        st_word = bus.data_in;
        ld_data = rd_word;
      end
    endcase
  end

  // Next-state, memory write port and response.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    ready_d      = 1'b0;
    resp_valid_d = 1'b0;
    data_out_d   = '0;
    err_d        = 1'b0;
    mem_we       = 1'b0;
    mem_waddr    = ptr_q;
    mem_wdata    = INIT_VAL;
    unique case (state_q)
      ST_INIT: begin
        mem_we = 1'b1;
        ptr_d  = ptr_q + IDX_W'(1);
        if (ptr_q == IDX_W'(DEPTH - 1)) begin
          state_d = ST_READY;
          ready_d = 1'b1;
        end
      end
      ST_READY: begin
        ready_d = 1'b1;
        if (accept) begin
          resp_valid_d = 1'b1;
          if (req_err) begin
            err_d = 1'b1;
          end else if (bus.is_st) begin
            mem_we    = 1'b1;
            mem_waddr = idx;
            mem_wdata = st_word;
          end else begin
            data_out_d = ld_data;
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_INIT;
      ptr_q        <= '0;
      ready_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      data_out_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      data_out_q   <= data_out_d;
      err_q        <= err_d;
    end
  end

  // Storage array; a request coinciding with reset never writes.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.data_out   = data_out_q;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl (DEPTH=16, INIT_VAL=5): directed table, corner sequences,
// and random traffic checked against a byte-array reference model.
module tb_data_memory_ctrl;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DEPTH    = 16;
  localparam logic [31:0] INIT_VAL = 32'h5;
  localparam int          NBYTES   = 4 * DEPTH;

  typedef struct {
    logic        ld;
    logic        st;
    logic [1:0]  sz;
    logic        sx;
    logic [31:0] addr;
    logic [31:0] din;
    logic        e;
    logic [31:0] q;
  } vec_t;

  logic clk;
  logic rst;
  int   vecs;
  int   errs;
  logic [7:0] mem_b [NBYTES];
  vec_t tbl[$];

  data_memory_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  data_memory_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .INIT_VAL(INIT_VAL)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_init();
    for (int i = 0; i < NBYTES; i++) mem_b[i] = INIT_VAL[8*(i%4) +: 8];
  endfunction

  // Reference behaviour computed on a flat byte array.
  function automatic void model_req(input logic ld, input logic st, input logic [1:0] sz,
                                    input logic sx, input logic [31:0] a, input logic [31:0] d,
                                    output logic e, output logic [31:0] q);
    int nb;
    logic [31:0] v;
    e = (ld == st) || (sz == 2'b11) || ((a >> 2) >= DEPTH) ||
        (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    q = '0;
    if (e) return;
    nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    if (st) begin
      for (int i = 0; i < nb; i++) mem_b[int'(a) + i] = d[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = mem_b[int'(a) + i];
      if (sx && nb == 1 && v[7])  v = v | 32'hFFFF_FF00;
      if (sx && nb == 2 && v[15]) v = v | 32'hFFFF_0000;
      q = v;
    end
  endfunction

  task automatic drive(input logic ld, input logic st, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] d);
    bus.req_valid = 1'b1;
    bus.is_ld     = ld;
    bus.is_st     = st;
    bus.size      = sz;
    bus.sign_ext  = sx;
    bus.address   = a;
    bus.data_in   = d;
  endtask

  task automatic check_resp(input string name, input logic v, input logic e, input logic [31:0] q);
    check(name, {29'h0, bus.req_ready, bus.resp_valid, bus.err, bus.data_out},
          {29'h0, 1'b1, v, e, q});
  endtask

  task automatic idle(input string name);
    bus.req_valid = 1'b0;
    tick();
    check_resp(name, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic add(input logic ld, input logic st, input logic [1:0] sz, input logic sx,
                     input logic [31:0] a, input logic [31:0] d, input logic e, input logic [31:0] q);
    vec_t v;
    v.ld = ld; v.st = st; v.sz = sz; v.sx = sx; v.addr = a; v.din = d; v.e = e; v.q = q;
    tbl.push_back(v);
  endtask

  // Counts cycles until req_ready rises; any response during that time is an error.
  task automatic wait_ready(output int n, output logic saw_resp);
    n = 0;
    saw_resp = 1'b0;
    while (!bus.req_ready && n < 100) begin
      tick();
      n++;
      if (bus.resp_valid) saw_resp = 1'b1;
    end
  endtask

  task automatic sweep_loads(input string name);
    logic e;
    logic [31:0] q;
    for (int w = 0; w < DEPTH; w++) begin
      model_req(1'b1, 1'b0, 2'b10, 1'b0, 32'(4 * w), 32'h0, e, q);
      drive(1'b1, 1'b0, 2'b10, 1'b0, 32'(4 * w), 32'h0);
      tick();
      check_resp($sformatf("%s_w%0d", name, w), 1'b1, e, q);
    end
    idle({name, "_idle"});
  endtask

  initial begin
    int n;
    logic saw;
    logic e;
    logic [31:0] q;
    vecs = 0;
    errs = 0;
    rst  = 1'b1;
    drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h0, 32'hFFFF_FFFF);
    tick();
    check("reset_state", {60'h0, bus.req_ready, bus.resp_valid, bus.err, |bus.data_out}, 64'h0);
    rst = 1'b0;
    // A store held valid during the sweep must never be accepted.
    wait_ready(n, saw);
    bus.req_valid = 1'b0;
    check("sweep_len", 64'(n), 64'd16);
    check("sweep_no_resp", {63'h0, saw}, 64'h0);
    model_init();
    sweep_loads("init5");

    // Directed table, applied back-to-back.
    add(0, 1, 2'b10, 0, 32'h28, 32'h1122_3344, 0, 32'h0);
    add(0, 1, 2'b00, 0, 32'h29, 32'h0000_00AB, 0, 32'h0);
    add(1, 0, 2'b10, 0, 32'h28, 32'h0,         0, 32'h1122_AB44);
    add(1, 0, 2'b00, 1, 32'h29, 32'h0,         0, 32'hFFFF_FFAB);
    add(1, 0, 2'b00, 0, 32'h29, 32'h0,         0, 32'h0000_00AB);
    add(0, 1, 2'b01, 0, 32'h3E, 32'h1234_8001, 0, 32'h0);
    add(1, 0, 2'b01, 1, 32'h3E, 32'h0,         0, 32'hFFFF_8001);
    add(1, 0, 2'b01, 0, 32'h3E, 32'h0,         0, 32'h0000_8001);
    add(1, 0, 2'b01, 1, 32'h3F, 32'h0,         1, 32'h0);
    add(0, 1, 2'b10, 0, 32'h00, 32'h0000_0009, 0, 32'h0);
    add(1, 0, 2'b10, 0, 32'h00, 32'h0,         0, 32'h0000_0009);
    add(0, 1, 2'b10, 0, 32'h40, 32'hDEAD_BEEF, 1, 32'h0);
    add(1, 1, 2'b10, 0, 32'h04, 32'h0,         1, 32'h0);
    add(0, 0, 2'b10, 0, 32'h04, 32'h0,         1, 32'h0);
    add(1, 0, 2'b11, 0, 32'h04, 32'h0,         1, 32'h0);
    add(1, 0, 2'b10, 0, 32'h06, 32'h0,         1, 32'h0);
    add(1, 0, 2'b00, 1, 32'h2A, 32'h0,         0, 32'h0000_0022);
    for (int i = 0; i < tbl.size(); i++) begin
      model_req(tbl[i].ld, tbl[i].st, tbl[i].sz, tbl[i].sx, tbl[i].addr, tbl[i].din, e, q);
      drive(tbl[i].ld, tbl[i].st, tbl[i].sz, tbl[i].sx, tbl[i].addr, tbl[i].din);
      tick();
      check_resp($sformatf("tbl%0d", i), 1'b1, tbl[i].e, tbl[i].q);
    end
    idle("tbl_idle");
    sweep_loads("after_tbl");

    // Random traffic with idle gaps.
    for (int k = 0; k < 400; k++) begin
      logic ld, st, sx;
      logic [1:0] sz;
      logic [31:0] a, d;
      int r, s;
      if ($urandom_range(0, 3) == 0) begin
        idle($sformatf("rnd_idle%0d", k));
        continue;
      end
      r  = int'($urandom_range(0, 9));
      ld = (r == 1) || (r >= 2 && r <= 5);
      st = (r == 1) || (r >= 6);
      s  = int'($urandom_range(0, 7));
      sz = (s == 7) ? 2'b11 : 2'(s % 3);
      sx = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, NBYTES + 7));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
      end
      d = $urandom();
      model_req(ld, st, sz, sx, a, d, e, q);
      drive(ld, st, sz, sx, a, d);
      tick();
      check_resp($sformatf("rnd%0d", k), 1'b1, e, q);
    end
    idle("rnd_end");
    sweep_loads("after_rnd");

    // Request coinciding with reset: discarded, no response.
    drive(0, 1, 2'b10, 0, 32'h10, 32'h77);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req_valid = 1'b0;
    check("rst_req_no_resp", {62'h0, bus.resp_valid, bus.req_ready}, 64'h0);
    // Reset again at sweep cycle 7: sweep restarts from word 0.
    for (int i = 0; i < 7; i++) tick();
    check("mid_sweep_not_ready", {63'h0, bus.req_ready}, 64'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_ready(n, saw);
    check("resweep_len", 64'(n), 64'd16);
    check("resweep_no_resp", {63'h0, saw}, 64'h0);
    model_init();
    sweep_loads("resweep5");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
